// File: rtl/synth_pkg.sv
// Shared synth-block definitions: voice allocator FSM encoding, voice classes, key width default.
package synth_pkg;

  localparam int KEY_W_DEF = 7;

  typedef enum logic {
    IDLE       = 1'b0,
    RETRIG_LOW = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    RELEASING = 2'd1,
    HELD      = 2'd2
  } vclass_t;

  function automatic vclass_t classify(input logic gate, input logic running);
    if (gate)
      return HELD;
    else if (running)
      return RELEASING;
    else
      return FREE;
  endfunction

endpackage

// File: rtl/voice_select.sv
// Combinational voice picker: key retrigger, then lowest free, then oldest releasing, then oldest held.
module voice_select
  import synth_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int KEY_W  = KEY_W_DEF,
  parameter int AGE_W  = 8
) (
  input  logic [VOICES-1:0]         gate,
  input  logic [VOICES-1:0]         running,
  input  logic [VOICES*AGE_W-1:0]   ages,
  input  logic [VOICES*KEY_W-1:0]   keys,
  input  logic [KEY_W-1:0]          req_key,
  output logic [$clog2(VOICES)-1:0] target,
  output logic                      steal
);

  localparam int IDX_W = $clog2(VOICES);

  logic             hit_ok, free_ok, rel_ok, held_ok;
  logic [IDX_W-1:0] hit_idx, free_idx, rel_idx, held_idx;
  logic [AGE_W-1:0] rel_age, held_age;

  always_comb begin
    hit_ok   = 1'b0;
    free_ok  = 1'b0;
    rel_ok   = 1'b0;
    held_ok  = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    rel_idx  = '0;
    held_idx = '0;
    rel_age  = '0;
    held_age = '0;
    // Strict '>' keeps the lowest index on age ties.
    for (int i = 0; i < VOICES; i++) begin
      case (classify(gate[i], running[i]))
        HELD: begin
          if (!hit_ok && keys[i*KEY_W +: KEY_W] == req_key) begin
            hit_ok  = 1'b1;
            hit_idx = IDX_W'(i);
          end
          if (!held_ok || ages[i*AGE_W +: AGE_W] > held_age) begin
            held_ok  = 1'b1;
            held_idx = IDX_W'(i);
            held_age = ages[i*AGE_W +: AGE_W];
          end
        end
        RELEASING: begin
          if (!rel_ok || ages[i*AGE_W +: AGE_W] > rel_age) begin
            rel_ok  = 1'b1;
            rel_idx = IDX_W'(i);
            rel_age = ages[i*AGE_W +: AGE_W];
          end
        end
        default: begin
          if (!free_ok) begin
            free_ok  = 1'b1;
            free_idx = IDX_W'(i);
          end
        end
      endcase
    end

    if (hit_ok) begin
      target = hit_idx;
      steal  = 1'b1;
    end else if (free_ok) begin
      target = free_idx;
      steal  = 1'b0;
    end else if (rel_ok) begin
      target = rel_idx;
      steal  = 1'b1;
    end else begin
      target = held_idx;
      steal  = 1'b1;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto ADSR voices, stealing with a one-cycle gate drop.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int KEY_W  = KEY_W_DEF,
  parameter int AGE_W  = 8
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    NoteOnValid,
  output logic                    NoteOnReady,
  input  logic [KEY_W-1:0]        NoteOnKey,
  input  logic                    NoteOffValid,
  input  logic [KEY_W-1:0]        NoteOffKey,
  input  logic [VOICES-1:0]       VoiceRunning,
  output logic [VOICES-1:0]       VoiceGate,
  output logic [VOICES*KEY_W-1:0] VoiceKey,
  output logic                    StealPulse
);

  localparam int               IDX_W   = $clog2(VOICES);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_MAX) ? a : a + 1'b1;
  endfunction

  state_t                   state, state_nxt;
  logic [VOICES-1:0]        gate_q, gate_nxt, off_hit, eff_gate;
  logic [VOICES*KEY_W-1:0]  key_q, key_nxt;
  logic [VOICES*AGE_W-1:0]  age_q, age_nxt;
  logic [IDX_W-1:0]         tgt_q, tgt_nxt, sel_idx, commit_idx;
  logic                     sel_steal, steal_nxt, steal_q, commit, accept;

  always_ff @(posedge Clock) begin
    assert (VOICES >= 2) else $error("voice_allocator: VOICES must be at least 2");
  end

  always_comb begin
    off_hit = '0;
    for (int i = 0; i < VOICES; i++)
      off_hit[i] = NoteOffValid && gate_q[i] && (key_q[i*KEY_W +: KEY_W] == NoteOffKey);
  end

  // Note-off takes effect before note-on selection in the same cycle.
  assign eff_gate = gate_q & ~off_hit;

  voice_select #(
    .VOICES (VOICES),
    .KEY_W  (KEY_W),
    .AGE_W  (AGE_W)
  ) u_select (
    .gate    (eff_gate),
    .running (VoiceRunning),
    .ages    (age_q),
    .keys    (key_q),
    .req_key (NoteOnKey),
    .target  (sel_idx),
    .steal   (sel_steal)
  );

  assign NoteOnReady = Reset && (state == IDLE);
  assign accept      = NoteOnValid && NoteOnReady;

  always_comb begin
    state_nxt  = state;
    gate_nxt   = eff_gate;
    key_nxt    = key_q;
    age_nxt    = age_q;
    tgt_nxt    = tgt_q;
    steal_nxt  = 1'b0;
    commit     = 1'b0;
    commit_idx = tgt_q;
    case (state)
      IDLE: begin
        if (accept) begin
          key_nxt[sel_idx*KEY_W +: KEY_W] = NoteOnKey;
          if (sel_steal) begin
            gate_nxt[sel_idx] = 1'b0;
            steal_nxt         = 1'b1;
            tgt_nxt           = sel_idx;
            state_nxt         = RETRIG_LOW;
          end else begin
            gate_nxt[sel_idx] = 1'b1;
            commit            = 1'b1;
            commit_idx        = sel_idx;
          end
        end
      end
      RETRIG_LOW: begin
        state_nxt = IDLE;
        // A note-off for the pending key abandons the re-raise.
        if (!(NoteOffValid && NoteOffKey == key_q[tgt_q*KEY_W +: KEY_W])) begin
          gate_nxt[tgt_q] = 1'b1;
          commit          = 1'b1;
          commit_idx      = tgt_q;
        end
      end
      default: state_nxt = IDLE;
    endcase

    for (int i = 0; i < VOICES; i++) begin
      if (!gate_q[i] && !VoiceRunning[i])
        age_nxt[i*AGE_W +: AGE_W] = '0;
      if (commit) begin
        if (IDX_W'(i) == commit_idx)
          age_nxt[i*AGE_W +: AGE_W] = '0;
        else if (gate_q[i] || VoiceRunning[i])
          age_nxt[i*AGE_W +: AGE_W] = sat_inc(age_q[i*AGE_W +: AGE_W]);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      gate_q  <= '0;
      key_q   <= '0;
      age_q   <= '0;
      tgt_q   <= '0;
      steal_q <= 1'b0;
    end else begin
      gate_q  <= gate_nxt;
      key_q   <= key_nxt;
      age_q   <= age_nxt;
      tgt_q   <= tgt_nxt;
      steal_q <= steal_nxt;
    end
  end

  assign VoiceGate  = gate_q;
  assign VoiceKey   = key_q;
  assign StealPulse = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator (VOICES=4): allocation, stealing, retrigger, note-off cancel, async reset.
module tb_voice_allocator;

  logic        Clock;
  logic        Reset;
  logic        NoteOnValid;
  logic        NoteOnReady;
  logic [6:0]  NoteOnKey;
  logic        NoteOffValid;
  logic [6:0]  NoteOffKey;
  logic [3:0]  VoiceRunning;
  logic [3:0]  VoiceGate;
  logic [27:0] VoiceKey;
  logic        StealPulse;

  typedef struct packed {
    logic [3:0]  g;
    logic [27:0] k;
    logic        s;
    logic        r;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  voice_allocator #(
    .VOICES (4),
    .KEY_W  (7),
    .AGE_W  (8)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .NoteOnValid  (NoteOnValid),
    .NoteOnReady  (NoteOnReady),
    .NoteOnKey    (NoteOnKey),
    .NoteOffValid (NoteOffValid),
    .NoteOffKey   (NoteOffKey),
    .VoiceRunning (VoiceRunning),
    .VoiceGate    (VoiceGate),
    .VoiceKey     (VoiceKey),
    .StealPulse   (StealPulse)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Key vector with voice 3 first, voice 0 last.
  function automatic logic [27:0] kv(input logic [6:0] k3, input logic [6:0] k2,
                                     input logic [6:0] k1, input logic [6:0] k0);
    return {k3, k2, k1, k0};
  endfunction

  task automatic step(input string tag,
                      input bit onv, input logic [6:0] onk,
                      input bit offv, input logic [6:0] offk,
                      input logic [3:0] run,
                      input logic [3:0] eg, input logic [27:0] ek,
                      input bit es, input bit er);
    exp_t e;
    NoteOnValid  = onv;
    NoteOnKey    = onk;
    NoteOffValid = offv;
    NoteOffKey   = offk;
    VoiceRunning = run;
    exp_q.push_back('{g: eg, k: ek, s: es, r: er});
    @(posedge Clock);
    #1;
    NoteOnValid  = 1'b0;
    NoteOffValid = 1'b0;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_gate"},  VoiceGate,   e.g);
      check({tag, "_key"},   VoiceKey,    e.k);
      check({tag, "_steal"}, StealPulse,  e.s);
      check({tag, "_ready"}, NoteOnReady, e.r);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset        = 1'b0;
    NoteOnValid  = 1'b0;
    NoteOnKey    = '0;
    NoteOffValid = 1'b0;
    NoteOffKey   = '0;
    VoiceRunning = '0;
    #3;
    check("rst_gate",  VoiceGate,   4'b0000);
    check("rst_key",   VoiceKey,    28'd0);
    check("rst_steal", StealPulse,  1'b0);
    check("rst_ready", NoteOnReady, 1'b0);
    @(posedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    check("rel_ready", NoteOnReady, 1'b1);

    // Fill voices in order
    step("on60", 1, 7'd60, 0, 7'd0, 4'b0000, 4'b0001, kv(0, 0, 0, 60),   0, 1);
    step("on62", 1, 7'd62, 0, 7'd0, 4'b0001, 4'b0011, kv(0, 0, 62, 60),  0, 1);
    step("on64", 1, 7'd64, 0, 7'd0, 4'b0011, 4'b0111, kv(0, 64, 62, 60), 0, 1);
    step("on65", 1, 7'd65, 0, 7'd0, 4'b0111, 4'b1111, kv(65, 64, 62, 60), 0, 1);

    // Steal oldest held voice 0; a note-on during the low cycle is refused
    step("on67",   1, 7'd67, 0, 7'd0, 4'b1111, 4'b1110, kv(65, 64, 62, 67), 1, 0);
    step("raise0", 1, 7'd70, 0, 7'd0, 4'b1111, 4'b1111, kv(65, 64, 62, 67), 0, 1);

    // Releasing voice 1 is preferred over held voices
    step("off62",  0, 7'd0, 1, 7'd62, 4'b1111, 4'b1101, kv(65, 64, 62, 67), 0, 1);
    step("on69",   1, 7'd69, 0, 7'd0, 4'b1111, 4'b1101, kv(65, 64, 69, 67), 1, 0);
    step("raise1", 0, 7'd0, 0, 7'd0, 4'b1111, 4'b1111, kv(65, 64, 69, 67), 0, 1);

    // Same-key retrigger on voice 0
    step("re67",   1, 7'd67, 0, 7'd0, 4'b1111, 4'b1110, kv(65, 64, 69, 67), 1, 0);
    step("raise2", 0, 7'd0, 0, 7'd0, 4'b1111, 4'b1111, kv(65, 64, 69, 67), 0, 1);

    // Simultaneous off/on 64, then off 64 during the low cycle cancels re-raise
    step("offon64", 1, 7'd64, 1, 7'd64, 4'b1111, 4'b1011, kv(65, 64, 69, 67), 1, 0);
    step("cancel",  0, 7'd0, 1, 7'd64, 4'b1111, 4'b1011, kv(65, 64, 69, 67), 0, 1);

    // Voice 2 goes free and takes a plain allocation
    step("on71", 1, 7'd71, 0, 7'd0, 4'b1011, 4'b1111, kv(65, 71, 69, 67), 0, 1);

    // All held: ages are v0=1 v1=2 v2=0 v3=4, so voice 3 is stolen
    step("on60b", 1, 7'd60, 0, 7'd0, 4'b1111, 4'b0111, kv(60, 71, 69, 67), 1, 0);

    // Async reset between edges while the re-raise is pending
    #2;
    Reset = 1'b0;
    #1;
    check("mid_rst_gate",  VoiceGate,   4'b0000);
    check("mid_rst_key",   VoiceKey,    28'd0);
    check("mid_rst_steal", StealPulse,  1'b0);
    check("mid_rst_ready", NoteOnReady, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    check("post_rst_ready", NoteOnReady, 1'b1);

    step("idle_after", 0, 7'd0, 0, 7'd0, 4'b0000, 4'b0000, kv(0, 0, 0, 0),  0, 1);
    step("on50",       1, 7'd50, 0, 7'd0, 4'b0000, 4'b0001, kv(0, 0, 0, 50), 0, 1);
    step("on52",       1, 7'd52, 0, 7'd0, 4'b0001, 4'b0011, kv(0, 0, 52, 50), 0, 1);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice scheduler sitting between the note-event source (MIDI decode) and a bank of VOICES ADSR envelope instances.
- Assigns each note-on to an ADSR voice and drives that voice's Gate and key. Routes note-offs to the voice(s) holding the key.
- Steals a voice when all are busy; a steal forces a one-cycle Gate low so the ADSR restarts from zero.

Parameters:
VOICES, 4, number of ADSR voices managed (2..16)
KEY_W, 7, note key width
AGE_W, 8, per-voice age counter width (saturating)

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset asserted)
NoteOnValid  input  1  note-on request valid
NoteOnReady  output  1  allocator can accept a note-on this cycle
NoteOnKey  input  KEY_W  key of note-on
NoteOffValid  input  1  note-off strobe (always accepted, no ready)
NoteOffKey  input  KEY_W  key of note-off
VoiceRunning  input  VOICES  Running flag from each ADSR
VoiceGate  output  VOICES  Gate to each ADSR
VoiceKey  output  VOICES*KEY_W  key held by voice i at bits [i*KEY_W +: KEY_W]
StealPulse  output  1  one-cycle pulse when a note-on steals or retriggers a voice

Behaviour:
- Reset (Reset==0, async): VoiceGate=0, VoiceKey=0, all ages=0, StealPulse=0, FSM=IDLE. NoteOnReady is 0 while Reset is asserted and 1 after release.
- Voice classes, evaluated each cycle:
  - free: Gate=0 and Running=0
  - releasing: Gate=0 and Running=1
  - held: Gate=1
- FSM states IDLE and RETRIG_LOW. NoteOnReady=1 only in IDLE.
- IDLE, note-on accepted (Valid&&Ready) — target selection, first match wins:
  1. A held voice whose VoiceKey==NoteOnKey: retrigger; lowest index if several.
  2. The lowest-index free voice.
  3. The releasing voice with the largest age; ties go to the lowest index.
  4. The held voice with the largest age; ties go to the lowest index.
- Case 2 (free voice):
  - On the next edge: VoiceGate[t]=1, VoiceKey[t]=NoteOnKey, age[t]=0.
  - Latency 1 cycle; stays in IDLE.
- Cases 1, 3, 4 (retrigger/steal):
  - Next edge: VoiceGate[t]=0, VoiceKey[t]=NoteOnKey, StealPulse=1, go to RETRIG_LOW.
  - Following edge: VoiceGate[t]=1, age[t]=0, return to IDLE.
  - Gate is therefore low for exactly one cycle; latency 2 cycles. The target index is registered.
- Ages:
  - On every edge where a note-on is committed (Gate rising on target t), every other voice with Gate=1 or Running=1 increments its age, saturating at 2^AGE_W-1.
  - Free voices keep age 0.
- Note-off:
  - Every voice with Gate=1 and VoiceKey==NoteOffKey drops Gate to 0 on the next edge.
  - VoiceKey is retained so the releasing voice can still be matched by case 1 only if it is held (it is not).
  - Note-off is processed in both states.
- Simultaneous events:
  - Note-off and note-on in the same cycle: note-off is applied first, so voices freed by it do not count as held for rule 1. Gate=0 voices still Running are releasing candidates.
  - A note-off that matches the RETRIG_LOW target key during RETRIG_LOW cancels the pending re-raise: Gate stays 0 and FSM returns to IDLE.
- Reset asserted mid-RETRIG_LOW: all Gates drop immediately; nothing is pending after release.
- StealPulse is high only on the cycle entering RETRIG_LOW.
- VOICES < 2 is illegal; this is checked by a simulation assertion.

Decomposition:
- Shared package (synth_pkg):
  - FSM state encoding constants (IDLE=1'b0, RETRIG_LOW=1'b1)
  - KEY_W default
  - voice-class encoding (FREE/RELEASING/HELD)
- One natural sub-module, voice_select: purely combinational priority/max-age picker.
  - Inputs: gate, running, ages, keys, request key.
  - Outputs: target index plus a retrigger/steal flag.
- The top module holds the FSM, age counters, gate/key registers and the note-off match.

Test Plan:
- Reset release, note-ons for keys 60,62,64 on consecutive cycles with VOICES=4 -> VoiceGate=0001,0011,0111 one cycle after each accept; keys 60/62/64 in voices 0/1/2; StealPulse never high.
- Fill all 4 voices (keys 60,62,64,65), then note-on 67 -> voice 0 (age 3, oldest) Gate goes 0 for exactly one cycle with StealPulse=1, then Gate=1 with key 67; NoteOnReady=0 during the low cycle.
- Voices full, note-off 62 with VoiceRunning[1] held 1, then note-on 69 -> voice 1 (releasing) is chosen over older held voices.
- Note-on 60 while voice 0 holds 60 -> same voice retriggered (Gate 1→0→1), no other voice changes.
- Note-off and note-on for the same key in the same cycle, plus note-off for the target key during RETRIG_LOW -> Gate stays 0, FSM back in IDLE, NoteOnReady=1 next cycle.
- Assert Reset (0) asynchronously mid-RETRIG_LOW between clock edges -> all VoiceGate=0 immediately without a clock edge; after release, NoteOnReady=1 and ages are 0.
